// File: rtl/acq_buffer.sv
// Sample-capture buffer: records NSAMPLE ADC words on an en_acq rising edge,
// then streams them out serially (MSB first) under ram_enr flow control.
module acq_buffer #(
  parameter int ADC_WIDTH  = 12,
  parameter int ADDR_WIDTH = 8,
  parameter int NSAMPLE    = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_acq,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic                 ram_enr,
  output logic                 ram_datao,
  output logic                 ram_valid,
  output logic                 busy,
  output logic                 data_ready,
  output logic                 done,
  output logic                 acq_miss
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = $clog2(ADC_WIDTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NSAMPLE - 1);
  localparam logic [CNT_W-1:0]      LAST_BIT  = CNT_W'(ADC_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQ,
    S_DONE,
    S_LOAD,
    S_SHIFT
  } state_t;

  state_t                 state_q, state_d;
  logic                   en_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [ADC_WIDTH-1:0]   shreg_q, shreg_d;
  logic                   done_q, done_d;
  logic                   acq_miss_q, acq_miss_d;
  logic                   mem_we;
  logic                   rise;

  logic [ADC_WIDTH-1:0]   mem [0:DEPTH-1];

  assign rise = en_acq & ~en_q;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    done_d     = 1'b0;
    acq_miss_d = 1'b0;
    mem_we     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d   = S_ACQ;
          wr_addr_d = '0;
        end
      end

      S_ACQ: begin
        mem_we     = 1'b1;
        acq_miss_d = rise;
        // Hold the address on the final write so it never wraps.
        if (wr_addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          wr_addr_d = wr_addr_q + 1'b1;
        end
      end

      S_DONE: begin
        // A readout request wins over a simultaneous rise, which is dropped.
        if (ram_enr) begin
          state_d   = S_LOAD;
          rd_addr_d = '0;
        end else if (rise) begin
          state_d   = S_ACQ;
          wr_addr_d = '0;
        end
      end

      S_LOAD: begin
        acq_miss_d = rise;
        shreg_d    = mem[rd_addr_q];
        bit_cnt_d  = '0;
        state_d    = S_SHIFT;
      end

      S_SHIFT: begin
        acq_miss_d = rise;
        if (ram_enr) begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            if (rd_addr_q == LAST_ADDR) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              rd_addr_d = rd_addr_q + 1'b1;
              state_d   = S_LOAD;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      done_q     <= 1'b0;
      acq_miss_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_acq;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      done_q     <= done_d;
      acq_miss_q <= acq_miss_d;
    end
  end

  // NOTE: the sample memory is deliberately not reset; data_ready gates its
  // use, and a reset port would prevent mapping onto RAM resources.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[wr_addr_q] <= adc_data;
    end
  end

  assign busy       = (state_q == S_ACQ);
  assign data_ready = (state_q == S_DONE);
  assign ram_valid  = (state_q == S_SHIFT);
  assign ram_datao  = (state_q == S_SHIFT) & shreg_q[ADC_WIDTH-1];
  assign done       = done_q;
  assign acq_miss   = acq_miss_q;

endmodule

// File: doc/acq_buffer.md
ACQ_BUFFER -- requirements
Module: acq_buffer

Interface
REQ-001 Parameter ADC_WIDTH, default 12, ADC sample width.
REQ-002 Parameter ADDR_WIDTH, default 8, sample memory address width (depth 2^ADDR_WIDTH).
REQ-003 Parameter NSAMPLE, default 10, samples captured per acquisition; legal range 1..2^ADDR_WIDTH.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en_acq  input  1  acquisition request; a rising edge triggers capture.
REQ-007 adc_data  input  ADC_WIDTH  ADC sample, sampled every clk edge.
REQ-008 ram_enr  input  1  readout enable; advances the serial output one bit per cycle.
REQ-009 ram_datao  output  1  serial readout bit, MSB first.
REQ-010 ram_valid  output  1  high while ram_datao carries a valid bit.
REQ-011 busy  output  1  high during capture.
REQ-012 data_ready  output  1  high while a complete capture awaits readout.
REQ-013 done  output  1  one-cycle pulse after the last bit has been consumed.
REQ-014 acq_miss  output  1  one-cycle pulse when an en_acq rising edge is ignored.

Function
REQ-015 en_acq shall be registered (en_q); rise = en_acq & ~en_q.
REQ-016 The FSM shall have states IDLE, ACQ, DONE, LOAD and SHIFT.
REQ-017 IDLE: on rise, go to ACQ and clear wr_addr; otherwise stay.
REQ-018 ACQ: each cycle, write adc_data to mem[wr_addr] and increment wr_addr.
REQ-019 ACQ: after the write at wr_addr = NSAMPLE-1, go to DONE; the first stored sample is adc_data at the edge after the rise edge.
REQ-020 DONE: ram_enr=1 shall clear rd_addr and go to LOAD.
REQ-021 DONE: rise with ram_enr=0 shall restart capture (go to ACQ, clear wr_addr, overwrite the buffer).
REQ-022 DONE: rise together with ram_enr=1 shall start readout; the rise is dropped without an acq_miss pulse.
REQ-023 LOAD: read mem[rd_addr] into a ADC_WIDTH shift register, clear the bit counter, and go to SHIFT; ram_enr is ignored.
REQ-024 SHIFT: ram_datao = shreg MSB; ram_valid = 1.
REQ-025 SHIFT: ram_enr=1 shall shift left one bit and increment the bit counter.
REQ-026 SHIFT: ram_enr=0 shall hold shreg, the counter and ram_datao.
REQ-027 SHIFT: on the ADC_WIDTH-th consumed bit, increment rd_addr and go to LOAD if rd_addr < NSAMPLE-1.
REQ-028 SHIFT: if that bit belongs to sample NSAMPLE-1, go to IDLE and pulse done in the following cycle.
REQ-029 Continuous ram_enr readout timing: DONE exit edge, 1 LOAD cycle, ADC_WIDTH SHIFT cycles per sample, 1 LOAD gap between samples; total NSAMPLE*(ADC_WIDTH+1) cycles after leaving DONE.
REQ-030 A rise in ACQ, LOAD or SHIFT shall be ignored and pulse acq_miss in the next cycle.
REQ-031 Output decode: busy = (state==ACQ); data_ready = (state==DONE); ram_valid = (state==SHIFT); ram_datao = 0 outside SHIFT.
REQ-032 Address counters shall be ADDR_WIDTH wide and never wrap within one operation.

Reset
REQ-033 Reset shall force state IDLE, wr_addr = rd_addr = bit counter = shreg = 0, and en_q = 0.
REQ-034 Reset shall force all outputs to 0 on the next edge and take priority over every other event, including mid-ACQ and mid-SHIFT.
REQ-035 Memory contents shall not be reset; data_ready after reset requires a new capture.
REQ-036 en_acq high at reset release counts as a rise.

Verification
REQ-037 adc_data = free-running count; rise sampled at the edge where adc_data = 4 -> mem[0..9] = 5..14; busy high for 10 cycles; data_ready asserted after the 10th write.
REQ-038 Scenario 1, then ram_enr held high -> ram_datao sequence 000000000101, 000000000110, ... 000000001110, with ram_valid low on each LOAD cycle; done pulses once; total 130 cycles.
REQ-039 ram_enr dropped for 3 cycles after bit 5 of sample 2 -> ram_datao and ram_valid hold; the stream resumes without bit loss or duplication.
REQ-040 Second rise during ACQ and during SHIFT -> acq_miss pulses each time; captured data and readout unaffected.
REQ-041 Reset asserted mid-SHIFT -> all outputs 0 next cycle, state IDLE; a new rise performs a full fresh capture.
REQ-042 In DONE, rise and ram_enr=1 in the same cycle -> readout starts, no acq_miss, buffer unchanged; a rise in DONE alone -> re-capture overwrites the buffer.
